// File: rtl/cordic_arbiter.sv
// cordic_arbiter: credit-gated round-robin sharing of one never-stalling cordic core by two requesters
// (CORDIC_ARB_PRIORITY_EN selects fixed rq0 priority). Response after CORE_LATENCY+1 cycles; stalled rsN blocks only rqN.

module cordic_arb_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    // Show-ahead: the head is visible without a pop.
    assign o_dout  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
endmodule

module cordic_arbiter #(
    parameter int CORE_LATENCY = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rq0_valid,
    output logic              o_rq0_ready,
    input  logic              i_rq0_op_mode,
    input  logic [DATA_W-1:0] i_rq0_x,
    input  logic [DATA_W-1:0] i_rq0_y,
    input  logic [DATA_W-1:0] i_rq0_angle,
    input  logic              i_rq1_valid,
    output logic              o_rq1_ready,
    input  logic              i_rq1_op_mode,
    input  logic [DATA_W-1:0] i_rq1_x,
    input  logic [DATA_W-1:0] i_rq1_y,
    input  logic [DATA_W-1:0] i_rq1_angle,
    output logic              o_rs0_valid,
    input  logic              i_rs0_ready,
    output logic              o_rs0_op_mode,
    output logic [DATA_W-1:0] o_rs0_a,
    output logic [DATA_W-1:0] o_rs0_b,
    output logic              o_rs1_valid,
    input  logic              i_rs1_ready,
    output logic              o_rs1_op_mode,
    output logic [DATA_W-1:0] o_rs1_a,
    output logic [DATA_W-1:0] o_rs1_b,
    output logic              o_core_op_mode,
    output logic [DATA_W-1:0] o_core_x,
    output logic [DATA_W-1:0] o_core_y,
    output logic [DATA_W-1:0] o_core_angle,
    input  logic [DATA_W-1:0] i_core_a,
    input  logic [DATA_W-1:0] i_core_b,
    output logic              o_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = 1 + 2 * DATA_W;

    logic [CW-1:0]           r_credit0, r_credit1;
    logic [CORE_LATENCY-1:0] r_tag_vld, r_tag_id, r_tag_op;
    logic                    w_elig0, w_elig1, w_gnt0, w_gnt1, w_issue;
    logic                    w_push0, w_push1, w_pop0, w_pop1;
    logic                    w_empty0, w_empty1;
    logic [RW-1:0]           w_push_dat, w_head0, w_head1;

    assign w_elig0 = i_rq0_valid & (r_credit0 != '0);
    assign w_elig1 = i_rq1_valid & (r_credit1 != '0);

`ifdef CORDIC_ARB_PRIORITY_EN
    assign w_gnt0 = w_elig0;
    assign w_gnt1 = w_elig1 & ~w_elig0;
`else
    logic r_last_grant;

    // On contention the requester not served last time wins.
    assign w_gnt0 = w_elig0 & (~w_elig1 | r_last_grant);
    assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_last_grant);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_last_grant <= 1'b1;
        else if (w_issue) r_last_grant <= w_gnt1;
    end
`endif

    assign w_issue     = w_gnt0 | w_gnt1;
    assign o_rq0_ready = w_gnt0;
    assign o_rq1_ready = w_gnt1;

    always_comb begin
        o_core_op_mode = 1'b0;
        o_core_x       = '0;
        o_core_y       = '0;
        o_core_angle   = '0;
        if (w_gnt0) begin
            o_core_op_mode = i_rq0_op_mode;
            o_core_x       = i_rq0_x;
            o_core_y       = i_rq0_y;
            o_core_angle   = i_rq0_angle;
        end else if (w_gnt1) begin
            o_core_op_mode = i_rq1_op_mode;
            o_core_x       = i_rq1_x;
            o_core_y       = i_rq1_y;
            o_core_angle   = i_rq1_angle;
        end
    end

    // Tag pipeline mirrors the core; its last stage lines up with the core output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_tag_op  <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[CORE_LATENCY-2:0], w_issue};
            r_tag_id  <= {r_tag_id[CORE_LATENCY-2:0], w_gnt1};
            r_tag_op  <= {r_tag_op[CORE_LATENCY-2:0], o_core_op_mode};
        end
    end

    assign w_push0    = r_tag_vld[CORE_LATENCY-1] & ~r_tag_id[CORE_LATENCY-1];
    assign w_push1    = r_tag_vld[CORE_LATENCY-1] &  r_tag_id[CORE_LATENCY-1];
    assign w_push_dat = {r_tag_op[CORE_LATENCY-1], i_core_a, i_core_b};
    assign w_pop0     = i_rs0_ready & ~w_empty0;
    assign w_pop1     = i_rs1_ready & ~w_empty1;

    cordic_arb_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push0),
        .i_din   (w_push_dat),
        .i_pop   (w_pop0),
        .o_dout  (w_head0),
        .o_empty (w_empty0)
    );

    cordic_arb_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push1),
        .i_din   (w_push_dat),
        .i_pop   (w_pop1),
        .o_dout  (w_head1),
        .o_empty (w_empty1)
    );

    // A credit covers a result from issue until it is popped from its FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_credit0 <= CW'(FIFO_DEPTH);
            r_credit1 <= CW'(FIFO_DEPTH);
        end else begin
            r_credit0 <= r_credit0 + CW'(w_pop0) - CW'(w_gnt0);
            r_credit1 <= r_credit1 + CW'(w_pop1) - CW'(w_gnt1);
        end
    end

    assign o_rs0_valid = ~w_empty0;
    assign o_rs1_valid = ~w_empty1;
    assign {o_rs0_op_mode, o_rs0_a, o_rs0_b} = w_head0;
    assign {o_rs1_op_mode, o_rs1_a, o_rs1_b} = w_head1;
    assign o_busy = (|r_tag_vld) | ~w_empty0 | ~w_empty1;
endmodule
